univ_shift_reg: RTL and testbench

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

---
 rtl/shift_pkg.sv | 24 ++
 rtl/shift_word_counter.sv | 39 +++
 rtl/univ_shift_reg.sv | 57 +++++
 tb/tb_univ_shift_reg.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - operation encodings and width helper for the universal shift register
package shift_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD = 3'd0,
        MODE_SHL  = 3'd1,
        MODE_SHR  = 3'd2,
        MODE_ASR  = 3'd3,
        MODE_ROL  = 3'd4,
        MODE_ROR  = 3'd5,
        MODE_LOAD = 3'd6,
        MODE_RSVD = 3'd7
    } shift_mode_t;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    function automatic logic is_shift_mode(input shift_mode_t m);
        return (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_ASR) ||
               (m == MODE_ROL) || (m == MODE_ROR);
    endfunction

endpackage

// File: rtl/shift_word_counter.sv
// rtl/shift_word_counter.sv - counts shifts per word and pulses done after the WIDTH-th shift
module shift_word_counter
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int CW = cnt_width(WIDTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          inc,
    input  logic          restart,
    output logic [CW-1:0] cnt,
    output logic          done
);

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (restart) begin
                cnt <= '0;
            end else if (inc) begin
                // Wrap on the last shift so the next shift is shift 1 of a new word
                if (cnt == LAST) begin
                    cnt  <= '0;
                    done <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - universal shift/rotate/load register with per-word shift counter
module univ_shift_reg
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int CW = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    input  shift_mode_t      mode,
    input  logic             ser_in_l,
    input  logic             ser_in_r,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             ser_out,
    output logic [CW-1:0]    cnt,
    output logic             word_done
);

    logic do_shift;
    logic do_load;

    assign do_shift = en && is_shift_mode(mode);
    assign do_load  = en && (mode == MODE_LOAD);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            q <= '0;
        end else if (en) begin
            case (mode)
                MODE_SHL:  q <= {q[WIDTH-2:0], ser_in_l};
                MODE_SHR:  q <= {ser_in_r, q[WIDTH-1:1]};
                MODE_ASR:  q <= {q[WIDTH-1], q[WIDTH-1:1]};
                MODE_ROL:  q <= {q[WIDTH-2:0], q[WIDTH-1]};
                MODE_ROR:  q <= {q[0], q[WIDTH-1:1]};
                MODE_LOAD: q <= d;
                default:   q <= q;
            endcase
        end
    end

    // Left-moving modes expose the MSB that is about to leave; all others expose the LSB
    assign ser_out = ((mode == MODE_SHL) || (mode == MODE_ROL)) ? q[WIDTH-1] : q[0];

    shift_word_counter #(.WIDTH(WIDTH)) u_word_counter (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear),
        .inc     (do_shift),
        .restart (do_load),
        .cnt     (cnt),
        .done    (word_done)
    );

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb/tb_univ_shift_reg.sv - directed self-checking bench for univ_shift_reg
module tb_univ_shift_reg;
    import shift_pkg::*;

    localparam int WIDTH = 8;
    localparam int CW = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             clear;
    logic             en;
    shift_mode_t      mode;
    logic             ser_in_l;
    logic             ser_in_r;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic             ser_out;
    logic [CW-1:0]    cnt;
    logic             word_done;

    int checks = 0;
    int errors = 0;
    int pulses;

    always #5 clk = ~clk;

    univ_shift_reg #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .en        (en),
        .mode      (mode),
        .ser_in_l  (ser_in_l),
        .ser_in_r  (ser_in_r),
        .d         (d),
        .q         (q),
        .ser_out   (ser_out),
        .cnt       (cnt),
        .word_done (word_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input shift_mode_t m);
        reset = 1'b0;
        clear = 1'b0;
        en    = 1'b1;
        mode  = m;
        step();
    endtask

    task automatic load(input logic [WIDTH-1:0] v);
        d = v;
        do_op(MODE_LOAD);
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; en = 1'b0; mode = MODE_HOLD;
        ser_in_l = 1'b0; ser_in_r = 1'b0; d = '0;
        step();
        check("rst_q", q, 0);
        check("rst_cnt", cnt, 0);
        check("rst_wd", word_done, 0);
        check("rst_ser_out", ser_out, 0);

        load(8'hA5);
        check("load_a5", q, 8'hA5);
        reset = 1'b1;
        step();
        check("rst2_q", q, 0);
        check("rst2_cnt", cnt, 0);
        check("rst2_wd", word_done, 0);

        load(8'h81);
        ser_in_l = 1'b1;
        mode = MODE_SHL;
        #1;
        check("ser_out_shl_pre", ser_out, 1);
        do_op(MODE_SHL);
        check("shl_q", q, 8'h03);
        check("shl_ser_out", ser_out, 0);
        check("shl_cnt", cnt, 1);
        ser_in_l = 1'b0;

        load(8'h81);
        check("load_cnt0", cnt, 0);
        do_op(MODE_ROR);
        check("ror_q", q, 8'hC0);
        load(8'h81);
        do_op(MODE_ASR);
        check("asr_q", q, 8'hC0);
        load(8'h81);
        ser_in_r = 1'b0;
        do_op(MODE_SHR);
        check("shr_q", q, 8'h40);
        check("shr_ser_out", ser_out, 0);
        do_op(MODE_ROL);
        check("rol_q", q, 8'h80);
        check("rol_ser_out", ser_out, 1);

        load(8'h5A);
        for (int i = 1; i <= 8; i++) begin
            do_op(MODE_SHL);
            check($sformatf("wc_cnt_%0d", i), cnt, i % 8);
            check($sformatf("wc_wd_%0d", i), word_done, (i == 8));
        end
        check("wc_q", q, 8'h00);
        do_op(MODE_HOLD);
        check("wc_wd_after_hold", word_done, 0);
        check("wc_hold_q", q, 8'h00);

        load(8'h5A);
        pulses = 0;
        for (int i = 1; i <= 16; i++) begin
            do_op(MODE_ROL);
            if (word_done) pulses++;
            check($sformatf("b2b_wd_%0d", i), word_done, (i == 8 || i == 16));
            check($sformatf("b2b_cnt_%0d", i), cnt, i % 8);
        end
        check("b2b_pulses", pulses, 2);
        check("b2b_q", q, 8'h5A);

        for (int i = 0; i < 7; i++) do_op(MODE_ROL);
        check("pre_load_cnt", cnt, 7);
        do_op(MODE_ROL);
        check("wd_before_load", word_done, 1);
        load(8'h11);
        check("wd_after_load", word_done, 0);

        load(8'h3C);
        clear = 1'b1; en = 1'b1; mode = MODE_LOAD; d = 8'hFF;
        step();
        check("clr_q", q, 0);
        check("clr_cnt", cnt, 0);
        check("clr_wd", word_done, 0);

        load(8'h5A);
        do_op(MODE_SHL);
        do_op(MODE_SHL);
        do_op(MODE_SHL);
        check("pri_q", q, 8'hD0);
        check("pri_cnt", cnt, 3);
        en = 1'b0; mode = MODE_SHL;
        step();
        check("en0_q", q, 8'hD0);
        check("en0_cnt", cnt, 3);

        do_op(shift_mode_t'(3'd7));
        check("ill_q", q, 8'hD0);
        check("ill_cnt", cnt, 3);
        check("ill_wd", word_done, 0);

        reset = 1'b1;
        step();
        check("midrst_cnt", cnt, 0);
        pulses = 0;
        for (int i = 1; i <= 7; i++) begin
            do_op(MODE_ROR);
            if (word_done) pulses++;
        end
        check("midrst_pulses", pulses, 0);
        check("midrst_cnt7", cnt, 7);

        en = 1'b0; clear = 1'b1; mode = MODE_SHL;
        step();
        check("clr_en0_cnt", cnt, 0);
        check("clr_en0_q", q, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
